flag_ram_rd_sched: RTL and testbench

//  Controller for the 1-bit-write / multi-bit-read sparsity-flag RAM. Owns both RAM ports.

---
 rtl/flag_pkg.sv | 27 ++
 rtl/flag_out_fifo.sv | 45 ++++
 rtl/flag_ram_rd_sched.sv | 140 ++++++++++++++
 tb/tb_flag_ram_rd_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared definitions for the sparsity-flag RAM read scheduler.
//   FLAG_MODE_*  : read-mode encoding (window = L flags/read, PE = 1 flag/read)
//   flag_state_e : scheduler FSM encoding
//   win_hit()    : wrap-aware test of whether addr lies in [base, base+len) mod 2^aw
package flag_pkg;

  localparam logic FLAG_MODE_WIN = 1'b0;
  localparam logic FLAG_MODE_PE  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } flag_state_e;

  // Distance from base to addr, taken modulo the address space, is below len
  // exactly when addr falls inside the (possibly wrapping) window.
  function automatic logic win_hit(input int unsigned addr, input int unsigned base,
                                   input int unsigned len, input int unsigned aw);
    int unsigned mask;
    int unsigned diff;
    mask = (32'd1 << aw) - 32'd1;
    diff = (addr - base) & mask;
    return diff < len;
  endfunction

endpackage

// File: rtl/flag_out_fifo.sv
// 2-entry valid/ready FIFO carrying {last, data} words to the PE array.
//   clk, reset        : clock, synchronous active-high reset (clears contents)
//   push, push_data   : write side; caller guarantees no push when full
//   pop               : consumer ready; a word leaves when out_valid & pop
//   out_valid/out_data: head of queue, held stable until popped
//   occ               : current occupancy 0..2
module flag_out_fifo #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [1:0][W-1:0] mem;
  logic              rptr, wptr;
  logic              push_fire, pop_fire;

  assign push_fire = push && (occ != 2'd2);
  assign pop_fire  = pop && (occ != 2'd0);
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem  <= '0;
      rptr <= 1'b0;
      wptr <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (push_fire) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop_fire) rptr <= ~rptr;
      occ <= occ + 2'(push_fire) - 2'(pop_fire);
    end
  end

endmodule

// File: rtl/flag_ram_rd_sched.sv
// Sparsity-flag RAM controller: forwards loader writes, walks a strided read
// sequence on cfg_start (PE or window mode) and streams returned flags to the
// PE array through a 2-deep valid/ready buffer.
//   cfg_*            : job config, sampled on cfg_start in IDLE
//   busy/done        : job status (done = 1-cycle completion pulse)
//   wr_*             : loader write port, passed straight to the RAM
//   ram_*            : RAM control; read data returns 1 cycle after ram_read_req
//   out_*            : flag word stream, out_last marks the job's final read
module flag_ram_rd_sched
  import flag_pkg::*;
#(
  parameter int ADDR_WIDTH       = 4,
  parameter int READ_FLAG_LENGTH = 6,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_start,
  input  logic                        cfg_mode,
  input  logic [ADDR_WIDTH-1:0]       cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]       cfg_stride,
  input  logic [CNT_WIDTH-1:0]        cfg_count,
  output logic                        busy,
  output logic                        done,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic                        wr_data,
  output logic                        ram_mode,
  output logic                        ram_write_req,
  output logic [ADDR_WIDTH-1:0]       ram_write_addr,
  output logic                        ram_write_data,
  output logic                        ram_read_req,
  output logic [ADDR_WIDTH-1:0]       ram_read_addr,
  input  logic                        ram_read_data_p,
  input  logic [READ_FLAG_LENGTH-1:0] ram_read_data_s,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [READ_FLAG_LENGTH-1:0] out_data,
  output logic                        out_last
);

  localparam int AW = ADDR_WIDTH;
  localparam int L  = READ_FLAG_LENGTH;
  localparam int CW = CNT_WIDTH;

  flag_state_e   state;
  logic          mode_q;
  logic [AW-1:0] rd_addr, stride_q;
  logic [CW-1:0] cnt_left;
  logic          inflight, inflight_last, zero_done;
  logic [1:0]    occ;
  logic          credit_ok, hazard, issue, drain_done;
  logic [L:0]    push_data, head;

  // Writes never stall; wr_ready only drops while in reset.
  assign ram_write_req  = wr_valid && wr_ready;
  assign ram_write_addr = wr_ready ? wr_addr : '0;
  assign ram_write_data = wr_ready && wr_data;

  // Write wins over a read whose window it touches; the read retries next cycle.
  assign hazard = ram_write_req &&
                  win_hit(32'(wr_addr), 32'(rd_addr),
                          (mode_q == FLAG_MODE_PE) ? 32'd1 : 32'(L), 32'(AW));

  // Buffered plus in-flight words never exceed the 2 FIFO slots.
  assign credit_ok = (occ == 2'd0) || ((occ == 2'd1) && !inflight);
  assign issue     = (state == ST_RUN) && credit_ok && !hazard;

  assign ram_read_req  = issue;
  assign ram_read_addr = rd_addr;
  assign ram_mode      = mode_q;
  assign busy          = (state != ST_IDLE);
  assign drain_done    = (state == ST_DRAIN) && !inflight && (occ == 2'd0);
  assign done          = drain_done || zero_done;

  assign push_data = {inflight_last,
                      (mode_q == FLAG_MODE_PE) ? {{(L-1){1'b0}}, ram_read_data_p}
                                               : ram_read_data_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mode_q        <= FLAG_MODE_PE;
      rd_addr       <= '0;
      stride_q      <= '0;
      cnt_left      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      zero_done     <= 1'b0;
      wr_ready      <= 1'b0;
    end else begin
      wr_ready      <= 1'b1;
      inflight      <= issue;
      inflight_last <= issue && (cnt_left == CW'(1));
      zero_done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            if (cfg_count != '0) begin
              mode_q   <= cfg_mode;
              rd_addr  <= cfg_base_addr;
              stride_q <= cfg_stride;
              cnt_left <= cfg_count;
              state    <= ST_RUN;
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            rd_addr  <= rd_addr + stride_q;
            cnt_left <= cnt_left - CW'(1);
            if (cnt_left == CW'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  flag_out_fifo #(.W(L + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_data),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (head),
    .occ       (occ)
  );

  assign out_last = head[L];
  assign out_data = head[L-1:0];

endmodule

// File: tb/tb_flag_ram_rd_sched.sv
module tb_flag_ram_rd_sched;
  localparam int AW = 4;
  localparam int L  = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_start = 1'b0, cfg_mode = 1'b1;
  logic [AW-1:0] cfg_base_addr = '0, cfg_stride = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          busy, done;
  logic          wr_valid = 1'b0, wr_ready, wr_data = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          ram_mode, ram_write_req, ram_write_data, ram_read_req;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic          ram_read_data_p = 1'b0;
  logic [L-1:0]  ram_read_data_s = '0;
  logic          out_valid, out_ready = 1'b1, out_last;
  logic [L-1:0]  out_data;

  flag_ram_rd_sched #(.ADDR_WIDTH(AW), .READ_FLAG_LENGTH(L), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_base_addr(cfg_base_addr),
    .cfg_stride(cfg_stride), .cfg_count(cfg_count), .busy(busy), .done(done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_mode(ram_mode), .ram_write_req(ram_write_req), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data), .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
    .ram_read_data_p(ram_read_data_p), .ram_read_data_s(ram_read_data_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Flag RAM model: bit i of mem is the flag at address i; reads registered.
  logic [15:0] mem = 16'hB2CD;
  always @(posedge clk) begin
    if (ram_write_req) mem[ram_write_addr] <= ram_write_data;
    if (ram_read_req) begin
      ram_read_data_p <= mem[ram_read_addr];
      for (int i = 0; i < L; i++) ram_read_data_s[i] <= mem[ram_read_addr + 4'(i)];
    end
  end

  // Monitor: logs reads, handshakes, done pulses and stability of stalled words.
  int          cyc = 0, iss = 0, cons = 0, done_cnt = 0, done_cyc = 0, stab_err = 0;
  logic [3:0]  rd_log[$];
  logic [5:0]  hs_data[$];
  logic        hs_last[$];
  int          hs_cyc[$];
  logic        stall_q = 1'b0, stall_last = 1'b0;
  logic [5:0]  stall_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_read_req) begin
      rd_log.push_back(ram_read_addr);
      iss <= iss + 1;
    end
    if (out_valid && out_ready) begin
      hs_data.push_back(out_data);
      hs_last.push_back(out_last);
      hs_cyc.push_back(cyc);
      cons <= cons + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (stall_q && (!out_valid || out_data != stall_data || out_last != stall_last))
      stab_err <= stab_err + 1;
    stall_q    <= out_valid && !out_ready && !reset;
    stall_data <= out_data;
    stall_last <= out_last;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic m, input logic [3:0] b, input logic [3:0] s,
                           input logic [7:0] c);
    cfg_mode = m; cfg_base_addr = b; cfg_stride = s; cfg_count = c; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 60 && done_cnt == d0; i++) step();
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic test_pe();
    int rb, hb;
    int ed[4] = '{1, 0, 1, 1};
    int ea[4] = '{0, 1, 2, 3};
    rb = rd_log.size(); hb = hs_data.size();
    out_ready = 1'b1;
    start_job(1'b1, 4'd0, 4'd1, 8'd4);
    chk("pe_busy", 32'(busy), 1);
    chk("pe_mode", 32'(ram_mode), 1);
    wait_done("pe_done");
    chk("pe_nwords", hs_data.size() - hb, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pe_data%0d", i), 32'(hs_data[hb+i]), ed[i]);
      chk($sformatf("pe_last%0d", i), 32'(hs_last[hb+i]), (i == 3) ? 1 : 0);
      chk($sformatf("pe_addr%0d", i), 32'(rd_log[rb+i]), ea[i]);
    end
    chk("pe_done_lat", done_cyc - hs_cyc[hb+3], 1);
    step();
    chk("pe_idle", 32'(busy), 0);
  endtask

  task automatic test_win();
    int rb, hb;
    int ed[3] = '{'h36, 'h0D, 'h33};
    int ea[3] = '{14, 0, 2};
    rb = rd_log.size(); hb = hs_data.size();
    start_job(1'b0, 4'd14, 4'd2, 8'd3);
    chk("win_mode", 32'(ram_mode), 0);
    wait_done("win_done");
    chk("win_nwords", hs_data.size() - hb, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("win_addr%0d", i), 32'(rd_log[rb+i]), ea[i]);
      chk($sformatf("win_data%0d", i), 32'(hs_data[hb+i]), ed[i]);
      chk($sformatf("win_last%0d", i), 32'(hs_last[hb+i]), (i == 2) ? 1 : 0);
    end
  endtask

  task automatic test_bp();
    int hb, mx;
    int ed[5] = '{0, 1, 0, 1, 1};
    hb = hs_data.size(); mx = 0;
    out_ready = 1'b1;
    start_job(1'b1, 4'd4, 4'd3, 8'd5);
    step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (iss - cons > mx) mx = iss - cons;
    end
    out_ready = 1'b1;
    wait_done("bp_done");
    chk("bp_maxbuf", mx, 2);
    chk("bp_stable", stab_err, 0);
    chk("bp_nwords", hs_data.size() - hb, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_data%0d", i), 32'(hs_data[hb+i]), ed[i]);
      chk($sformatf("bp_last%0d", i), 32'(hs_last[hb+i]), (i == 4) ? 1 : 0);
    end
  endtask

  task automatic test_hazard();
    int hb;
    // window at 4 covers 4..9; write to 7 must win and delay the read
    hb = hs_data.size();
    start_job(1'b0, 4'd4, 4'd1, 8'd1);
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 1'b0;
    #1;
    chk("hz_wreq", 32'(ram_write_req), 1);
    chk("hz_stall", 32'(ram_read_req), 0);
    step();
    wr_valid = 1'b0;
    #1;
    chk("hz_reissue", 32'(ram_read_req), 1);
    chk("hz_raddr", 32'(ram_read_addr), 4);
    wait_done("hz_done");
    chk("hz_data", 32'(hs_data[hb]), 'h24);
    chk("hz_bit3", 32'(hs_data[hb][3]), 0);
    // write to 11 is outside the window: both issue together
    hb = hs_data.size();
    start_job(1'b0, 4'd4, 4'd1, 8'd1);
    wr_valid = 1'b1; wr_addr = 4'd11; wr_data = 1'b1;
    #1;
    chk("nz_wreq", 32'(ram_write_req), 1);
    chk("nz_rreq", 32'(ram_read_req), 1);
    step();
    wr_valid = 1'b0;
    wait_done("nz_done");
    chk("nz_data", 32'(hs_data[hb]), 'h24);
    // window at 14 wraps to 3; write to 1 is inside it
    start_job(1'b0, 4'd14, 4'd1, 8'd1);
    wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 1'b0;
    #1;
    chk("wz_stall", 32'(ram_read_req), 0);
    step();
    wr_valid = 1'b0;
    wait_done("wz_done");
  endtask

  task automatic test_zero_busy();
    int i0, d0, rb, hb;
    i0 = iss;
    start_job(1'b1, 4'd0, 4'd1, 8'd0);
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);
    step();
    chk("z_done_off", 32'(done), 0);
    step();
    chk("z_noread", iss - i0, 0);
    d0 = done_cnt; rb = rd_log.size(); hb = hs_data.size();
    start_job(1'b1, 4'd0, 4'd1, 8'd2);
    cfg_base_addr = 4'd8; cfg_count = 8'd3; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    wait_done("ib_done");
    repeat (4) step();
    chk("ib_ndone", done_cnt - d0, 1);
    chk("ib_nreads", rd_log.size() - rb, 2);
    chk("ib_addr1", 32'(rd_log[rb+1]), 1);
    chk("ib_nwords", hs_data.size() - hb, 2);
  endtask

  task automatic test_reset();
    int d0;
    bit seen;
    out_ready = 1'b0;
    start_job(1'b1, 4'd0, 4'd1, 8'd1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) seen = 1;
      else step();
    end
    chk("rs_queued", 32'(seen), 1);
    d0 = done_cnt;
    reset = 1'b1;
    step();
    chk("rs_busy", 32'(busy), 0);
    chk("rs_done", 32'(done), 0);
    chk("rs_wrdy", 32'(wr_ready), 0);
    chk("rs_rreq", 32'(ram_read_req), 0);
    chk("rs_raddr", 32'(ram_read_addr), 0);
    chk("rs_mode", 32'(ram_mode), 1);
    chk("rs_oval", 32'(out_valid), 0);
    chk("rs_olast", 32'(out_last), 0);
    chk("rs_odata", 32'(out_data), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("rs_nodone", done_cnt - d0, 0);
    chk("rs_idle", 32'(busy), 0);
    chk("rs_empty", 32'(out_valid), 0);
  endtask

  initial begin
    repeat (3) step();
    chk("init_busy", 32'(busy), 0);
    chk("init_wrdy", 32'(wr_ready), 0);
    chk("init_mode", 32'(ram_mode), 1);
    chk("init_oval", 32'(out_valid), 0);
    reset = 1'b0;
    step();
    chk("init_wrdy_up", 32'(wr_ready), 1);
    test_pe();
    test_win();
    test_bp();
    test_hazard();
    test_zero_busy();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule
